// File: rtl/cpu_fetch_pkg.sv
// Shared types and defaults for the instruction fetch responder.
// Holds the FSM state encoding and the timeout counter width helper.
package cpu_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 16;
    localparam int TIMEOUT_DEF = 16;

    function automatic int to_cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int TO_CNT_W = to_cnt_w(TIMEOUT_DEF);

endpackage

// File: rtl/fetch_timeout_cnt.sv
// Watchdog for an outstanding memory read: counts cycles while en, restarts on clr.
// Latency: expired is combinational from the count; no backpressure of its own.
module fetch_timeout_cnt
    import cpu_fetch_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = to_cnt_w(TIMEOUT);

    logic [CW-1:0] cnt;

    // The count equals the number of already-elapsed cycles, so the last
    // allowed cycle is TIMEOUT-1 and the FSM leaves on that edge.
    assign expired = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/instr_fetch_resp.sv
// Fetch responder: instr_query -> memory read at pc -> one-cycle run pulse; FETCH_TIMEOUT_EN adds a watchdog/ERR state.
// Latency: run 2 cycles after query plus one per mem_ack wait cycle; mem_req is held until mem_ack.
module instr_fetch_resp
    import cpu_fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_query,
    output logic               run,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  pc_load_val,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_ack,
    input  logic               clear_err,
    output logic               fetch_err
);

    state_t state;
    logic   ack_taken;

    assign ack_taken = (state == REQ) && mem_ack;

`ifdef FETCH_TIMEOUT_EN
    logic to_expired;

    fetch_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (state != REQ),
        .en      (state == REQ),
        .expired (to_expired)
    );
`else
    logic unused_clear_err;
    assign unused_clear_err = clear_err;
    assign fetch_err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            run      <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            instr    <= '0;
`ifdef FETCH_TIMEOUT_EN
            fetch_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    run <= 1'b0;
                    if (instr_query) begin
                        state    <= REQ;
                        mem_addr <= pc;
                        mem_req  <= 1'b1;
                    end
                end
                // No cancel path: a dropped query still completes the read.
                REQ: begin
                    if (mem_ack) begin
                        instr   <= mem_rdata;
                        mem_req <= 1'b0;
                        run     <= 1'b1;
                        state   <= HOLD;
`ifdef FETCH_TIMEOUT_EN
                    end else if (to_expired) begin
                        mem_req   <= 1'b0;
                        fetch_err <= 1'b1;
                        state     <= ERR;
`endif
                    end
                end
                HOLD: begin
                    run   <= 1'b0;
                    state <= IDLE;
                end
                ERR: begin
`ifdef FETCH_TIMEOUT_EN
                    if (clear_err) begin
                        fetch_err <= 1'b0;
                        state     <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: begin
                    run     <= 1'b0;
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // A branch target loaded on the ack edge wins over the sequential increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
        end else if (pc_load) begin
            pc <= pc_load_val;
        end else if (ack_taken) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: tb/tb_instr_fetch_resp.sv
// Scoreboard bench for instr_fetch_resp: a memory responder with programmable wait/hang,
// expected fetch results queued at query time and checked when run pulses. Covers FETCH_TIMEOUT_EN when defined.
module tb_instr_fetch_resp;

    localparam int AW = 8;
    localparam int IW = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          instr_query = 1'b0;
    logic          run;
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
    logic          pc_load = 1'b0;
    logic [AW-1:0] pc_load_val = '0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic          clear_err = 1'b0;
    logic          fetch_err;

    instr_fetch_resp #(
        .ADDR_W  (AW),
        .INSTR_W (IW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_query (instr_query),
        .run         (run),
        .instr       (instr),
        .pc          (pc),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .clear_err   (clear_err),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [IW-1:0] mem [256];
    int            wait_cycles = 0;
    bit            hang = 1'b0;
    bit            stray_ack = 1'b0;
    bit            load_on_ack = 1'b0;
    logic [AW-1:0] load_val = '0;
    logic [AW-1:0] model_pc = '0;
    logic [IW-1:0] model_instr = '0;

    typedef struct {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
        logic [AW-1:0] addr;
        int            lat;
        int            reqc;
    } exp_t;
    exp_t exp_q[$];

    // Memory responder: acks after wait_cycles REQ cycles; can also pulse pc_load with the ack.
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                if (!hang && wcnt >= wait_cycles) begin
                    mem_ack     = 1'b1;
                    mem_rdata   = mem[mem_addr];
                    pc_load     = load_on_ack;
                    pc_load_val = load_val;
                    wcnt        = 0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 16'hBEEF;
                    pc_load   = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack   = stray_ack;
                mem_rdata = 16'hDEAD;
                pc_load   = 1'b0;
                wcnt      = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_fetch(input string nm, input int wt, input bit ld,
                            input logic [AW-1:0] lv, input bit drop);
        exp_t e;
        exp_t got;
        int   c;
        int   reqc;
        bit   seen;
        c = 0; reqc = 0; seen = 1'b0;
        wait_cycles = wt; load_on_ack = ld; load_val = lv; hang = 1'b0;
        e.instr = mem[model_pc];
        e.addr  = model_pc;
        e.pc    = ld ? lv : model_pc + 8'd1;
        e.lat   = 2 + wt;
        e.reqc  = 1 + wt;
        exp_q.push_back(e);
        model_pc = e.pc;
        instr_query = 1'b1;
        while (!seen && c < 60) begin
            @(negedge clk);
            c++;
            if (mem_req === 1'b1) begin
                reqc++;
                tests++;
                if (mem_addr !== e.addr) begin
                    fails++;
                    $display("FAIL %s mem_addr: got %h expected %h", nm, mem_addr, e.addr);
                end
                if (drop) instr_query = 1'b0;
            end
            tests++;
            if (run === 1'b1 && mem_req === 1'b1) begin
                fails++;
                $display("FAIL %s overlap: run and mem_req both high at cycle %0d", nm, c);
            end
            if (run === 1'b1) begin
                seen = 1'b1;
                instr_query = 1'b0;
            end
        end
        instr_query = 1'b0;
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s run_timeout: no run within %0d cycles", nm, c);
            void'(exp_q.pop_front());
        end else begin
            got = exp_q.pop_front();
            model_instr = got.instr;
            tests++;
            if (c != got.lat) begin
                fails++;
                $display("FAIL %s latency: got %0d expected %0d", nm, c, got.lat);
            end
            tests++;
            if (reqc != got.reqc) begin
                fails++;
                $display("FAIL %s req_cycles: got %0d expected %0d", nm, reqc, got.reqc);
            end
            tests++;
            if (instr !== got.instr) begin
                fails++;
                $display("FAIL %s instr: got %h expected %h", nm, instr, got.instr);
            end
            tests++;
            if (pc !== got.pc) begin
                fails++;
                $display("FAIL %s pc: got %h expected %h", nm, pc, got.pc);
            end
        end
        @(negedge clk);
        tests++;
        if (run !== 1'b0 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL %s after_run: run=%b mem_req=%b expected 0/0", nm, run, mem_req);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({run, mem_req, fetch_err} !== 3'b000) begin
            fails++;
            $display("FAIL reset_ctrl: run/mem_req/fetch_err=%b expected 000", {run, mem_req, fetch_err});
        end
        tests++;
        if (pc !== 8'h00 || mem_addr !== 8'h00 || instr !== 16'h0000) begin
            fails++;
            $display("FAIL reset_regs: pc=%h mem_addr=%h instr=%h expected zeros", pc, mem_addr, instr);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (mem_req !== 1'b0 || run !== 1'b0) begin
            fails++;
            $display("FAIL idle_quiet: mem_req=%b run=%b expected 0/0", mem_req, run);
        end
        model_pc = '0;
        model_instr = '0;
    endtask

    task automatic test_stray_ack();
        stray_ack = 1'b1;
        repeat (4) @(negedge clk);
        tests++;
        if (instr !== model_instr || run !== 1'b0 || mem_req !== 1'b0 || pc !== model_pc) begin
            fails++;
            $display("FAIL stray_ack: instr=%h run=%b mem_req=%b pc=%h expected %h 0 0 %h",
                     instr, run, mem_req, pc, model_instr, model_pc);
        end
        stray_ack = 1'b0;
        @(negedge clk);
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        int c;
        int reqc;
        int errc;
        bit run_seen;
        c = 0; reqc = 0; errc = 0; run_seen = 1'b0;
        hang = 1'b1;
        instr_query = 1'b1;
        while (c < 12) begin
            @(negedge clk);
            c++;
            if (mem_req === 1'b1) begin
                reqc++;
                instr_query = 1'b0;
            end
            if (run === 1'b1) run_seen = 1'b1;
            if (fetch_err === 1'b1 && errc == 0) errc = c;
        end
        tests++;
        if (reqc != TO) begin
            fails++;
            $display("FAIL timeout_req_cycles: got %0d expected %0d", reqc, TO);
        end
        tests++;
        if (errc != TO + 1) begin
            fails++;
            $display("FAIL timeout_err_cycle: got %0d expected %0d", errc, TO + 1);
        end
        tests++;
        if (run_seen || pc !== model_pc) begin
            fails++;
            $display("FAIL timeout_no_run: run_seen=%b pc=%h expected 0 %h", run_seen, pc, model_pc);
        end
        stray_ack = 1'b1;
        repeat (2) @(negedge clk);
        stray_ack = 1'b0;
        tests++;
        if (instr !== model_instr || fetch_err !== 1'b1 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL late_ack: instr=%h fetch_err=%b mem_req=%b expected %h 1 0",
                     instr, fetch_err, mem_req, model_instr);
        end
        hang = 1'b0;
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        tests++;
        if (fetch_err !== 1'b0) begin
            fails++;
            $display("FAIL clear_err: fetch_err=%b expected 0", fetch_err);
        end
        do_fetch("after_clear", 1, 1'b0, 8'h00, 1'b0);
    endtask
`else
    task automatic test_timeout();
        do_fetch("long_wait", 20, 1'b0, 8'h00, 1'b0);
        tests++;
        if (fetch_err !== 1'b0) begin
            fails++;
            $display("FAIL no_timeout_err: fetch_err=%b expected 0", fetch_err);
        end
    endtask
`endif

    task automatic test_reset_mid_req();
        int c;
        c = 0;
        hang = 1'b1;
        instr_query = 1'b1;
        while (mem_req !== 1'b1 && c < 5) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        tests++;
        if (mem_req !== 1'b1) begin
            fails++;
            $display("FAIL mid_req_setup: mem_req=%b expected 1", mem_req);
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({run, mem_req, fetch_err} !== 3'b000 || pc !== 8'h00 || mem_addr !== 8'h00 || instr !== 16'h0000) begin
            fails++;
            $display("FAIL async_reset: run=%b mem_req=%b err=%b pc=%h addr=%h instr=%h expected all zero",
                     run, mem_req, fetch_err, pc, mem_addr, instr);
        end
        instr_query = 1'b0;
        hang = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_pc = '0;
        model_instr = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests++;
            if (run !== 1'b0 || mem_req !== 1'b0) begin
                fails++;
                $display("FAIL post_reset_quiet: cycle %0d run=%b mem_req=%b expected 0/0", i, run, mem_req);
            end
        end
        do_fetch("post_reset_fetch", 0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {8'(i) ^ 8'h5A, ~8'(i)};
        mem[0] = 16'hA5A5;

        test_reset();
        do_fetch("zero_wait", 0, 1'b0, 8'h00, 1'b0);
        do_fetch("wait3", 3, 1'b0, 8'h00, 1'b0);
        do_fetch("set_pc10", 1, 1'b1, 8'h10, 1'b0);
        do_fetch("load_on_ack", 0, 1'b1, 8'h40, 1'b0);
        do_fetch("set_pcff", 0, 1'b1, 8'hFF, 1'b0);
        do_fetch("wrap", 2, 1'b0, 8'h00, 1'b0);
        do_fetch("query_drop", 2, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) do_fetch("back_to_back", i % 3, 1'b0, 8'h00, 1'b0);
        test_stray_ack();
        test_timeout();
        test_reset_mid_req();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch_resp.md
Name: instr_fetch_resp

Overview:
- Responder side of the instruction-query/run handshake driven by the CPU execution sequencer.
- On `instr_query`, reads program memory at the internal PC through a req/ack memory port and latches the returned word into an instruction register.
- Signals completion with a single-cycle `run` pulse, which the sequencer consumes to enter its run cycle.
- Owns the PC: increments after each fetch and accepts a branch/jump load.

Parameters:
- ADDR_W, 8, PC and memory address width.
- INSTR_W, 16, instruction word width.
- TIMEOUT, 16, max cycles waiting for `mem_ack`; used only with FETCH_TIMEOUT_EN; legal range 2..65535.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_query  in  1  fetch request level from the sequencer.
- run  out  1  one-cycle pulse: `instr` is valid, execute now.
- instr  out  INSTR_W  latched instruction register.
- pc  out  ADDR_W  current program counter.
- pc_load  in  1  load `pc_load_val` into PC.
- pc_load_val  in  ADDR_W  jump/branch target.
- mem_req  out  1  memory read request, held until ack.
- mem_addr  out  ADDR_W  registered read address.
- mem_rdata  in  INSTR_W  read data, valid when `mem_ack`=1.
- mem_ack  in  1  read completion; same-cycle ack allowed.
- clear_err  in  1  clears `fetch_err` and leaves the ERR state.
- fetch_err  out  1  sticky fetch-timeout flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; pc=0, instr=0, mem_addr=0.
  - run=0, mem_req=0, fetch_err=0; timeout count=0.
- IDLE:
  - instr_query=1 → REQ next cycle; mem_addr<=pc captured at this edge.
  - instr_query=0 → stay.
- REQ:
  - mem_req=1; mem_addr stays stable for the whole request.
  - On mem_ack=1: instr<=mem_rdata, pc<=pc+1 (wraps 2^ADDR_W-1→0), go to HOLD.
- HOLD:
  - run=1 for exactly this cycle; mem_req=0; always → IDLE next cycle.
  - The sequencer drops `instr_query` during its run cycle and re-raises it afterwards, so back-to-back fetches restart from IDLE.
- Latency:
  - Query seen in cycle N with ack in the first REQ cycle → run in cycle N+2.
  - Each extra wait cycle on `mem_ack` adds one cycle.
- pc_load:
  - Sampled in every state; pc<=pc_load_val.
  - Has priority over the post-ack increment in the same cycle.
  - Does not alter an in-flight `mem_addr`.
- instr_query dropped while in REQ: the request is not aborted (no cancel on memory port); data is still captured and run is still pulsed.
- mem_ack outside REQ: ignored.
- run and mem_req are never high simultaneously.
- `instr` changes only on an accepted ack.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ, cleared on REQ entry.
  - If TIMEOUT cycles pass in REQ without ack → ERR state: mem_req=0, run never pulses, fetch_err=1, pc unchanged.
  - clear_err=1 in ERR → IDLE next cycle with fetch_err=0. clear_err in other states has no effect.
  - A late mem_ack while in ERR is ignored.
- Undefined: no counter and no ERR state; REQ waits indefinitely; fetch_err tied to 0; clear_err unused.

Decomposition:
- Package cpu_fetch_pkg holds:
  - the state enum (IDLE, REQ, HOLD, ERR);
  - default ADDR_W/INSTR_W constants;
  - the timeout counter width as $clog2(TIMEOUT+1).
- Sub-module fetch_timeout_cnt (clear/enable/expired) is instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
- Reset, then query with zero-wait memory returning 16'hA5A5 → mem_req one cycle, mem_addr=0, run pulse 2 cycles after query, instr=A5A5, pc=1.
- Ack delayed 3 cycles → mem_req held 4 cycles, mem_addr stable, run 5 cycles after query, run and mem_req never overlap.
- pc_load=1 with pc_load_val=8'h40 in the same cycle as ack from pc=8'h10 → pc=8'h40 (not 8'h11), instr captured.
- pc=8'hFF, fetch completes → pc wraps to 8'h00.
- FETCH_TIMEOUT_EN, TIMEOUT=4, no ack → ERR after 4 REQ cycles, fetch_err=1, no run. clear_err → IDLE and fetch_err=0; a new query fetches normally.
- Assert reset mid-REQ → outputs return to reset values immediately (asynchronously), state IDLE, no run pulse after release.
